// File: rtl/branch_pc_unit.sv
// Fetch PC register and branch/jump resolution for the instruction in EX.
// A taken redirect loads the target and squashes IF/ID for exactly one (non-stalled) cycle.
module branch_pc_unit #(
   parameter int          WIDTH    = 32,
   parameter logic [31:0] RESET_PC = 32'h0,
   parameter int          CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             branch,
   input  logic             branchNe,
   input  logic             jump,
   input  logic             zeroFlag,
   input  logic [WIDTH-1:0] pcEX,
   input  logic [WIDTH-1:0] branchOffset,
   input  logic [WIDTH-1:0] jumpTarget,
   output logic [WIDTH-1:0] pc,
   output logic [WIDTH-1:0] pcPlus4,
   output logic             flush,
   output logic [CNT_W-1:0] branchCount,
   output logic [CNT_W-1:0] takenCount,
   output logic             dbgState
);

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_FLUSH = 1'b1
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] pc_next;
   logic             flush_next;
   logic             taken;
   logic [WIDTH-1:0] target;
   logic             branch_inc;
   logic             taken_inc;

   assign pcPlus4  = pc + WIDTH'(4);
   assign dbgState = state;

   // Jump takes priority over a simultaneously flagged branch.
   assign taken  = jump | (branch & (zeroFlag ^ branchNe));
   assign target = jump ? {jumpTarget[WIDTH-1:2], 2'b00}
                        : pcEX + {branchOffset[WIDTH-3:0], 2'b00};

   // State register together with the datapath registers it gates.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_RUN;
         pc          <= WIDTH'(RESET_PC);
         flush       <= 1'b0;
         branchCount <= '0;
         takenCount  <= '0;
      end else begin
         state <= state_next;
         pc    <= pc_next;
         flush <= flush_next;
         if (branch_inc && (branchCount != '1)) begin
            branchCount <= branchCount + 1'b1;
         end
         if (taken_inc && (takenCount != '1)) begin
            takenCount <= takenCount + 1'b1;
         end
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_RUN: begin
            if (!stall && taken) begin
               state_next = ST_FLUSH;
            end
         end
         ST_FLUSH: begin
            if (!stall) begin
               state_next = ST_RUN;
            end
         end
         default: state_next = ST_RUN;
      endcase
   end

   // In FLUSH the EX instruction is wrong-path, so its branch inputs are ignored.
   always_comb begin
      pc_next    = pc;
      flush_next = flush;
      branch_inc = 1'b0;
      taken_inc  = 1'b0;
      case (state)
         ST_RUN: begin
            if (!stall) begin
               branch_inc = branch & ~jump;
               taken_inc  = taken;
               if (taken) begin
                  pc_next    = target;
                  flush_next = 1'b1;
               end else begin
                  pc_next    = pcPlus4;
                  flush_next = 1'b0;
               end
            end
         end
         ST_FLUSH: begin
            if (stall) begin
               flush_next = 1'b1;
            end else begin
               pc_next    = pcPlus4;
               flush_next = 1'b0;
            end
         end
         default: begin
            pc_next    = pc;
            flush_next = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_branch_pc_unit.sv
// Directed bench for branch_pc_unit: a default instance and a 2-bit-counter instance
// share the stimulus and are checked every cycle against a behavioural model.
module tb_branch_pc_unit;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        branch;
   logic        branchNe;
   logic        jump;
   logic        zeroFlag;
   logic [31:0] pcEX;
   logic [31:0] branchOffset;
   logic [31:0] jumpTarget;

   logic [31:0] pc;
   logic [31:0] pcPlus4;
   logic        flush;
   logic [15:0] branchCount;
   logic [15:0] takenCount;
   logic        dbgState;

   logic [31:0] pc_s;
   logic [31:0] pcPlus4_s;
   logic        flush_s;
   logic [1:0]  branchCount_s;
   logic [1:0]  takenCount_s;
   logic        dbgState_s;

   int checks = 0;
   int errors = 0;

   branch_pc_unit #(.WIDTH(32), .RESET_PC(32'h0), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .stall(stall), .branch(branch), .branchNe(branchNe),
      .jump(jump), .zeroFlag(zeroFlag), .pcEX(pcEX), .branchOffset(branchOffset),
      .jumpTarget(jumpTarget), .pc(pc), .pcPlus4(pcPlus4), .flush(flush),
      .branchCount(branchCount), .takenCount(takenCount), .dbgState(dbgState)
   );

   branch_pc_unit #(.WIDTH(32), .RESET_PC(32'h0), .CNT_W(2)) dut_s (
      .clk(clk), .rst(rst), .stall(stall), .branch(branch), .branchNe(branchNe),
      .jump(jump), .zeroFlag(zeroFlag), .pcEX(pcEX), .branchOffset(branchOffset),
      .jumpTarget(jumpTarget), .pc(pc_s), .pcPlus4(pcPlus4_s), .flush(flush_s),
      .branchCount(branchCount_s), .takenCount(takenCount_s), .dbgState(dbgState_s)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // behavioural model
   bit          m_valid = 1'b0;
   logic [31:0] m_pc;
   bit          m_flush;
   int          m_bc;
   int          m_tc;

   function automatic int sat(input int v, input int w);
      int lim;
      lim = (1 << w) - 1;
      return (v > lim) ? lim : v;
   endfunction

   always @(posedge clk) begin
      bit          tk;
      logic [31:0] tgt;
      tk  = jump || (branch && (zeroFlag != branchNe));
      tgt = jump ? (jumpTarget & 32'hFFFF_FFFC) : (pcEX + branchOffset * 4);
      if (rst) begin
         m_pc = 32'h0; m_flush = 1'b0; m_bc = 0; m_tc = 0;
         m_valid = 1'b1;
      end else if (!m_valid || stall) begin
         // hold
      end else if (m_flush) begin
         m_pc = m_pc + 4; m_flush = 1'b0;
      end else begin
         if (branch && !jump) m_bc = m_bc + 1;
         if (tk) m_tc = m_tc + 1;
         m_pc    = tk ? tgt : m_pc + 4;
         m_flush = tk;
      end
   end

   // scoreboard
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (m_valid) begin
         check("pc", pc, m_pc);
         check("pcPlus4", pcPlus4, m_pc + 32'd4);
         check("flush", {31'd0, flush}, {31'd0, m_flush});
         check("state", {31'd0, dbgState}, {31'd0, m_flush});
         check("branchCount", {16'd0, branchCount}, 32'(sat(m_bc, 16)));
         check("takenCount", {16'd0, takenCount}, 32'(sat(m_tc, 16)));
         check("pc_s", pc_s, m_pc);
         check("flush_s", {31'd0, flush_s}, {31'd0, m_flush});
         check("branchCount_s", {30'd0, branchCount_s}, 32'(sat(m_bc, 2)));
         check("takenCount_s", {30'd0, takenCount_s}, 32'(sat(m_tc, 2)));
      end
   end

   // driver tasks
   task automatic drive(input logic b, input logic bne, input logic j, input logic zf,
                        input logic [31:0] pe, input logic [31:0] off,
                        input logic [31:0] jt, input logic st);
      branch = b; branchNe = bne; jump = j; zeroFlag = zf;
      pcEX = pe; branchOffset = off; jumpTarget = jt; stall = st;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic lit(input string name, input logic [31:0] exp_pc, input logic exp_flush);
      check({name, "_pc"}, pc, exp_pc);
      check({name, "_flush"}, {31'd0, flush}, {31'd0, exp_flush});
      check({name, "_model_pc"}, m_pc, exp_pc);
   endtask

   initial begin
      rst = 1'b1;
      idle();
      @(negedge clk);
      tick();
      lit("reset", 32'h0, 1'b0);
      check("reset_bc", {16'd0, branchCount}, 32'd0);
      check("reset_tc", {16'd0, takenCount}, 32'd0);
      rst = 1'b0;
      repeat (3) tick();
      lit("free_run", 32'hC, 1'b0);

      // BEQ taken, then a wrong-path branch during FLUSH is ignored
      drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h10, 32'h3, 32'h0, 1'b0);
      tick();
      lit("beq_taken", 32'h1C, 1'b1);
      drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h80, 32'h8, 32'h0, 1'b0);
      tick();
      lit("beq_after", 32'h20, 1'b0);

      // BNE not taken
      drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h20, 32'h40, 32'h0, 1'b0);
      tick();
      lit("bne_not_taken", 32'h24, 1'b0);
      check("bne_bc", {16'd0, branchCount}, 32'd2);
      check("bne_tc", {16'd0, takenCount}, 32'd1);

      // stall in RUN holds everything even with a taken branch present
      drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h24, 32'h10, 32'h0, 1'b1);
      tick();
      lit("stall_run", 32'h24, 1'b0);

      // jump wins over branch; stall extends FLUSH
      drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h24, 32'h10, 32'h103, 1'b0);
      tick();
      lit("jump", 32'h100, 1'b1);
      drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h24, 32'h10, 32'h200, 1'b1);
      tick();
      lit("flush_stall", 32'h100, 1'b1);
      idle();
      tick();
      lit("flush_release", 32'h104, 1'b0);
      check("jump_bc", {16'd0, branchCount}, 32'd2);
      check("jump_tc", {16'd0, takenCount}, 32'd2);

      // negative offset
      drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h40, 32'hFFFF_FFFE, 32'h0, 1'b0);
      tick();
      lit("neg_offset", 32'h38, 1'b1);
      idle();
      tick();

      // wrap on branch target and on sequential increment
      drive(1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h1, 32'h0, 1'b0);
      tick();
      lit("wrap_branch", 32'h0, 1'b1);
      idle();
      tick();
      drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'hFFFF_FFFC, 1'b0);
      tick();
      lit("jump_top", 32'hFFFF_FFFC, 1'b1);
      check("pcPlus4_wrap", pcPlus4, 32'h0);
      idle();
      tick();
      lit("wrap_seq", 32'h0, 1'b0);

      // five taken branches saturate the 2-bit counters
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h200, 32'h0, 32'h0, 1'b0);
         tick();
         idle();
         tick();
      end
      check("sat_tc_s", {30'd0, takenCount_s}, 32'd3);
      check("sat_bc_s", {30'd0, branchCount_s}, 32'd3);
      check("sat_tc", {16'd0, takenCount}, 32'd10);

      // reset while in FLUSH
      drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h300, 32'h4, 32'h0, 1'b0);
      tick();
      lit("pre_rst", 32'h310, 1'b1);
      rst = 1'b1;
      idle();
      tick();
      lit("rst_in_flush", 32'h0, 1'b0);
      rst = 1'b0;
      tick();
      lit("post_rst", 32'h4, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
